timer_mmss_ctrl: RTL and testbench
==================================

Name: timer_mmss_ctrl

Overview:
Countdown timer core that consumes the 1 Hz square wave from the 15-stage 32768 Hz ripple divider. Synchronises and edge-detects that wave on the system clock and decrements a BCD mm:ss count once per second. Provides load, start and pause control, a done flag and a one-cycle alarm pulse. Sits directly downstream of the 1 Hz divider and feeds the display/alarm logic.

Parameters:
MAX_MIN, 99, largest loadable minute value (decimal, 1..99); applied as the clamp for ld_min.

Ports:
clk  input  1  system clock (32768 Hz, same source as the divider input)
clr  input  1  reset; synchronous and active-low
tick_1hz  input  1  1 Hz square wave from divider out; asynchronous to clk
load  input  1  load ld_min/ld_sec and enter IDLE
ld_min  input  8  BCD minutes {tens,ones}
ld_sec  input  8  BCD seconds {tens,ones}
start  input  1  begin/resume countdown
pause  input  1  hold countdown
min_bcd  output  8  current minutes, BCD
sec_bcd  output  8  current seconds, BCD
running  output  1  high while state==RUN
done  output  1  high in DONE
alarm  output  1  one-clk pulse on reaching 00:00

Behaviour:
- Reset: synchronous, sampled on clk rising edge while clr==0. State=IDLE; min_bcd=0x00; sec_bcd=0x00; running=0; done=0; alarm=0. Sync flops s0/s1/s2=0.
- Tick path: s0<=tick_1hz, s1<=s0, s2<=s1. tick_p = s1 & ~s2.
  - The first clk edge sampling tick_1hz high is edge k; tick_p is high between k+1 and k+2; the count updates at edge k+2.
  - The sync chain runs in every state, so resume never produces a stale tick.
- States:
  - IDLE: start with count!=00:00 -> RUN. start with count==00:00 is ignored.
  - RUN: tick_p decrements the count. pause -> PAUSE.
  - PAUSE: tick_p is ignored. start -> RUN.
  - DONE: holds 00:00. start and pause are ignored. Exit only via load or reset.
- Priority, per clk: reset > load > pause > start > tick.
  - load in any state -> IDLE, count=loaded value, done=0, alarm=0. Any coincident tick is discarded.
  - start and pause together: pause wins (RUN->PAUSE; PAUSE stays PAUSE).
- Load validation, each field independent:
  - ld_sec with either nibble >9 or value >0x59 loads 0x59.
  - ld_min with either nibble >9 or value >MAX_MIN loads MAX_MIN in BCD.
- Decrement (BCD digit counters, no binary conversion):
  - sec_ones>0: sec_ones-1.
  - else if sec_tens>0: sec_ones=9, sec_tens-1.
  - else (sec==00): sec=0x59 and minutes decrement the same way (ones 0 -> 9 with a borrow from tens).
- Terminal: when a decrement yields 00:00, on that same edge state->DONE, running=0, done=1, alarm=1 for exactly one clk.
- running, done and alarm are registered outputs; no combinational paths from inputs.
- Reset mid-countdown: count clears to 00:00 on the next edge with clr==0; no alarm is generated.

Test Plan:
- Reset then idle: clr=0 for 3 clk with tick_1hz toggling -> min_bcd=0x00, sec_bcd=0x00, running=0, done=0, alarm never high.
- Load 0x01/0x02, start, run 3 ticks -> sec_bcd 0x02->0x01->0x00 then min=0x00 sec=0x59. Each change lands exactly 2 clk after the first high sample of tick_1hz.
- Load 0x00/0x02, start, 2 ticks -> count reaches 00:00; done=1 and alarm=1 for one clk on the same edge; further ticks leave 00:00; start is ignored.
- Load 0x00/0x10, start, pause after 1 tick (0x09), 3 ticks while paused -> stays 0x09. Start resumes: next tick -> 0x08. start+pause in the same clk -> PAUSE.
- Load coincident with tick_p while RUN at 0x05/0x00 -> count equals the loaded value with no decrement; state=IDLE. Load 0x7A/0x75 with MAX_MIN=99 -> min_bcd=0x99 (invalid digit A), sec_bcd=0x59.
- Start with count 00:00 in IDLE -> state stays IDLE, running=0. clr=0 mid-RUN at 0x03/0x30 -> next edge 00:00 in IDLE, done=0, alarm=0.

Source files
------------

// File: rtl/timer_mmss_ctrl.sv
// BCD mm:ss countdown timer driven by an asynchronous 1 Hz square wave.
// The wave is synchronised and rise-detected on clk; the count moves once per rising edge while running.
module timer_mmss_ctrl #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic [1:0] state_dbg
);

  // Handshake note: there is no valid/ready pair here; load/start/pause are
  // level controls sampled every clk, resolved as load > pause > start > tick.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MAX_TENS    = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES    = 4'(MAX_MIN % 10);
  localparam logic [7:0] MAX_MIN_BCD = {MAX_TENS, MAX_ONES};

  state_t     state;
  logic       s0, s1, s2;
  logic       tick_p;
  logic [7:0] ld_min_v;
  logic [7:0] ld_sec_v;
  logic [7:0] dec_min;
  logic [7:0] dec_sec;
  logic       dec_zero;
  logic       count_zero;

  assign tick_p     = s1 & ~s2;
  assign state_dbg  = state;
  assign count_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);

  // Both operands are valid BCD when compared, so BCD ordering equals numeric ordering.
  always_comb begin
    ld_sec_v = ld_sec;
    if ((ld_sec[7:4] > 4'd9) || (ld_sec[3:0] > 4'd9) || (ld_sec > 8'h59))
      ld_sec_v = 8'h59;
    ld_min_v = ld_min;
    if ((ld_min[7:4] > 4'd9) || (ld_min[3:0] > 4'd9) || (ld_min > MAX_MIN_BCD))
      ld_min_v = MAX_MIN_BCD;
  end

  always_comb begin
    dec_sec = sec_bcd;
    dec_min = min_bcd;
    if (sec_bcd[3:0] != 4'd0) begin
      dec_sec[3:0] = sec_bcd[3:0] - 4'd1;
    end else if (sec_bcd[7:4] != 4'd0) begin
      dec_sec = {sec_bcd[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec = 8'h59;
      if (min_bcd[3:0] != 4'd0)
        dec_min[3:0] = min_bcd[3:0] - 4'd1;
      else if (min_bcd[7:4] != 4'd0)
        dec_min = {min_bcd[7:4] - 4'd1, 4'd9};
      else
        dec_min = 8'h00;
    end
    dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= ST_IDLE;
      min_bcd <= 8'h00;
      sec_bcd <= 8'h00;
      running <= 1'b0;
      done    <= 1'b0;
      alarm   <= 1'b0;
      s0      <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
    end else begin
      // Sync chain always runs so a resume never sees a stale edge.
      s0    <= tick_1hz;
      s1    <= s0;
      s2    <= s1;
      alarm <= 1'b0;
      if (load) begin
        state   <= ST_IDLE;
        min_bcd <= ld_min_v;
        sec_bcd <= ld_sec_v;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!pause && start && !count_zero) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (pause) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end else if (tick_p) begin
              min_bcd <= dec_min;
              sec_bcd <= dec_sec;
              if (dec_zero) begin
                state   <= ST_DONE;
                running <= 1'b0;
                done    <= 1'b1;
                alarm   <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (!pause && start) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_mmss_ctrl.sv
// Directed bench for timer_mmss_ctrl: a seconds-based model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_timer_mmss_ctrl;

  localparam int MAX_MIN = 99;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic       tick_1hz;
  logic       load;
  logic [7:0] ld_min;
  logic [7:0] ld_sec;
  logic       start;
  logic       pause;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarm;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int alarm_cnt = 0;
  bit chk_en = 0;

  // Model: remaining time in whole seconds plus a mode.
  int m_secs = 0;
  int m_mode = M_IDLE;
  bit m_alarm = 0;
  bit samp[$];

  timer_mmss_ctrl #(.MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .clr(clr), .tick_1hz(tick_1hz), .load(load),
    .ld_min(ld_min), .ld_sec(ld_sec), .start(start), .pause(pause),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running),
    .done(done), .alarm(alarm), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int sec_field(input logic [7:0] b);
    int t = int'(b[7:4]);
    int o = int'(b[3:0]);
    if (t > 9 || o > 9 || (t * 10 + o) > 59) return 59;
    return t * 10 + o;
  endfunction

  function automatic int min_field(input logic [7:0] b);
    int t = int'(b[7:4]);
    int o = int'(b[3:0]);
    if (t > 9 || o > 9 || (t * 10 + o) > MAX_MIN) return MAX_MIN;
    return t * 10 + o;
  endfunction

  // A high sample of tick_1hz following a low one takes effect two edges later.
  always @(posedge clk) begin
    bit tp;
    m_alarm = 0;
    if (!clr) begin
      m_secs = 0;
      m_mode = M_IDLE;
      samp.push_back(1'b0); samp.push_back(1'b0); samp.push_back(1'b0);
    end else begin
      tp = samp[$-1] && !samp[$-2];
      samp.push_back(tick_1hz);
      if (load) begin
        m_secs = min_field(ld_min) * 60 + sec_field(ld_sec);
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE:  if (!pause && start && m_secs != 0) m_mode = M_RUN;
          M_RUN: begin
            if (pause) m_mode = M_PAUSE;
            else if (tp) begin
              m_secs--;
              if (m_secs == 0) begin
                m_mode  = M_DONE;
                m_alarm = 1;
              end
            end
          end
          M_PAUSE: if (!pause && start) m_mode = M_RUN;
          default: m_mode = M_DONE;
        endcase
      end
    end
    while (samp.size() > 4) void'(samp.pop_front());
    #1;
    if (chk_en) begin
      check("min_bcd", min_bcd, to_bcd(m_secs / 60));
      check("sec_bcd", sec_bcd, to_bcd(m_secs % 60));
      check("state", {6'd0, state_dbg}, 8'(m_mode));
      check("running", {7'd0, running}, {7'd0, m_mode == M_RUN});
      check("done", {7'd0, done}, {7'd0, m_mode == M_DONE});
      check("alarm", {7'd0, alarm}, {7'd0, m_alarm});
      if (alarm === 1'b1) alarm_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
    load = 1; ld_min = mm; ld_sec = ss;
    cyc(1);
    load = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(1); start = 0;
  endtask

  task automatic one_tick();
    tick_1hz = 1; cyc(4);
    tick_1hz = 0; cyc(4);
  endtask

  initial begin
    int a0;
    clr = 0; tick_1hz = 0; load = 0; ld_min = 0; ld_sec = 0; start = 0; pause = 0;
    cyc(1);
    chk_en = 1;
    tick_1hz = 1; cyc(1); tick_1hz = 0; cyc(1);
    check("rst_min", min_bcd, 8'h00);
    check("rst_sec", sec_bcd, 8'h00);
    check("rst_run", {7'd0, running}, 8'h00);
    check("rst_alarm_cnt", 8'(alarm_cnt), 8'h00);
    clr = 1; cyc(2);

    // 01:02 countdown with exact tick latency.
    do_load(8'h01, 8'h02);
    pulse_start();
    cyc(2);
    tick_1hz = 1;
    @(posedge clk); #2 check("lat_k", sec_bcd, 8'h02);
    @(posedge clk); #2 check("lat_k1", sec_bcd, 8'h02);
    @(posedge clk); #2 check("lat_k2", sec_bcd, 8'h01);
    @(negedge clk); cyc(1);
    tick_1hz = 0; cyc(4);
    one_tick();
    check("t2_sec", sec_bcd, 8'h00);
    one_tick();
    check("t2_min", min_bcd, 8'h00);
    check("t2_sec59", sec_bcd, 8'h59);
    check("t2_run", {7'd0, running}, 8'h01);

    // 00:02 to terminal.
    a0 = alarm_cnt;
    do_load(8'h00, 8'h02);
    pulse_start();
    one_tick();
    one_tick();
    check("t3_done", {7'd0, done}, 8'h01);
    check("t3_alarm_once", 8'(alarm_cnt - a0), 8'h01);
    one_tick();
    pulse_start();
    check("t3_hold_sec", sec_bcd, 8'h00);
    check("t3_hold_run", {7'd0, running}, 8'h00);

    // Pause and resume from 00:10.
    do_load(8'h00, 8'h10);
    pulse_start();
    one_tick();
    check("t4_09", sec_bcd, 8'h09);
    pause = 1; cyc(1); pause = 0;
    one_tick(); one_tick(); one_tick();
    check("t4_paused", sec_bcd, 8'h09);
    pulse_start();
    one_tick();
    check("t4_08", sec_bcd, 8'h08);
    start = 1; pause = 1; cyc(1); start = 0; pause = 0;
    check("t4_sp_state", {6'd0, state_dbg}, 8'h02);

    // Load coincident with tick_p while running at 05:00.
    do_load(8'h05, 8'h00);
    pulse_start();
    cyc(2);
    tick_1hz = 1;
    cyc(2);
    do_load(8'h05, 8'h00);
    check("t5_min", min_bcd, 8'h05);
    check("t5_sec", sec_bcd, 8'h00);
    check("t5_idle", {6'd0, state_dbg}, 8'h00);
    tick_1hz = 0; cyc(4);
    do_load(8'h7A, 8'h75);
    check("t5_clamp_min", min_bcd, 8'h99);
    check("t5_clamp_sec", sec_bcd, 8'h59);
    do_load(8'h45, 8'h60);
    check("t5_ok_min", min_bcd, 8'h45);
    check("t5_clamp60", sec_bcd, 8'h59);

    // Start at 00:00 is ignored; reset mid-run.
    do_load(8'h00, 8'h00);
    pulse_start();
    check("t6_idle", {6'd0, state_dbg}, 8'h00);
    check("t6_norun", {7'd0, running}, 8'h00);
    a0 = alarm_cnt;
    do_load(8'h03, 8'h30);
    pulse_start();
    one_tick();
    check("t6_329", sec_bcd, 8'h29);
    clr = 0; cyc(1);
    check("t6_rst_min", min_bcd, 8'h00);
    check("t6_rst_sec", sec_bcd, 8'h00);
    check("t6_rst_done", {7'd0, done}, 8'h00);
    clr = 1; cyc(3);
    check("t6_no_alarm", 8'(alarm_cnt - a0), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
